div_unit: RTL

Iterative 32-bit signed/unsigned integer divider that feeds the execute stage. The execute stage sends operands to it for `div`/`divu`, holds `start_i` high and raises its stall request until `ready_o` asserts. It then writes `result_o[63:32]` to HI and `result_o[31:0]` to LO. The divider computes one quotient bit per cycle by restoring shift-subtract, and can be annulled mid-operation when the pipeline flushes.

---
 rtl/div_unit_if.sv | 25 ++
 rtl/div_unit.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/div_unit_if.sv
// div_unit_if: operand/result bundle between the execute stage and the divider.
//   master (execute stage): drives signed_div_i, opdata1_i, opdata2_i,
//                           start_i, annul_i; observes result_o, ready_o.
//   slave  (div_unit)     : the reverse.
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic               signed_div_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               start_i;
  logic               annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_unit.sv
// div_unit: iterative signed/unsigned integer divider, one quotient bit per
// clock by restoring shift-subtract. Result is {remainder, quotient}; the
// remainder takes the sign of the dividend, the quotient truncates toward 0.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous reset, active-high, highest priority
//   bus  - div_unit_if.slave: operands, start/annul request, result/ready
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start_i (with annul_i low)
// BYZERO | divisor was zero; next edge publishes a zero result
// ON     | shift-subtract iterations, r_cnt counts 0..WIDTH
// END    | result_o/ready_o held until the consumer drops start_i
module div_unit #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       rst,
  div_unit_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_dividend;   // shifts left, feeding its MSB into the remainder
  logic [WIDTH-1:0]   r_divisor;    // divisor magnitude
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic               r_qneg;
  logic               r_rneg;
  logic [2*WIDTH-1:0] r_result;
  logic               r_ready;

  logic             w_accept;
  logic             w_op1_neg;
  logic             w_op2_neg;
  logic [WIDTH-1:0] w_op1_mag;
  logic [WIDTH-1:0] w_op2_mag;
  logic [WIDTH:0]   w_partial;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;

  assign w_accept  = bus.start_i && !bus.annul_i;

  // Magnitudes only when signed; -(-2^(W-1)) wraps to itself, which is the
  // correct unsigned magnitude 2^(W-1).
  assign w_op1_neg = bus.signed_div_i && bus.opdata1_i[WIDTH-1];
  assign w_op2_neg = bus.signed_div_i && bus.opdata2_i[WIDTH-1];
  assign w_op1_mag = w_op1_neg ? (~bus.opdata1_i + WIDTH'(1)) : bus.opdata1_i;
  assign w_op2_mag = w_op2_neg ? (~bus.opdata2_i + WIDTH'(1)) : bus.opdata2_i;

  // The partial remainder is WIDTH+1 bits; after a successful subtract the
  // difference is below the divisor, so its low WIDTH bits are exact.
  assign w_partial = {r_rem, r_dividend[WIDTH-1]};
  assign w_ge      = (w_partial >= {1'b0, r_divisor});
  assign w_diff    = w_partial[WIDTH-1:0] - r_divisor;

  assign w_quo_fix = r_qneg ? (~r_quo + WIDTH'(1)) : r_quo;
  assign w_rem_fix = r_rneg ? (~r_rem + WIDTH'(1)) : r_rem;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = (bus.opdata2_i == '0) ? S_BYZERO : S_ON;
        end
      end
      S_BYZERO: begin
        w_state_next = bus.annul_i ? S_IDLE : S_END;
      end
      S_ON: begin
        if (bus.annul_i) begin
          w_state_next = S_IDLE;
        end else if (r_cnt == CNT_DONE) begin
          w_state_next = S_END;
        end
      end
      S_END: begin
        if (!bus.start_i) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_qneg     <= 1'b0;
      r_rneg     <= 1'b0;
      r_result   <= '0;
      r_ready    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt      <= '0;
            r_dividend <= w_op1_mag;
            r_divisor  <= w_op2_mag;
            r_rem      <= '0;
            r_quo      <= '0;
            r_qneg     <= w_op1_neg ^ w_op2_neg;
            r_rneg     <= w_op1_neg;
          end
        end
        S_BYZERO: begin
          if (!bus.annul_i) begin
            r_result <= '0;
            r_ready  <= 1'b1;
          end
        end
        S_ON: begin
          if (bus.annul_i) begin
            r_cnt <= '0;
          end else if (r_cnt == CNT_DONE) begin
            r_result <= {w_rem_fix, w_quo_fix};
            r_ready  <= 1'b1;
          end else begin
            r_rem      <= w_ge ? w_diff : w_partial[WIDTH-1:0];
            r_quo      <= {r_quo[WIDTH-2:0], w_ge};
            r_dividend <= {r_dividend[WIDTH-2:0], 1'b0};
            r_cnt      <= r_cnt + CNT_W'(1);
          end
        end
        S_END: begin
          if (!bus.start_i) begin
            r_result <= '0;
            r_ready  <= 1'b0;
            r_cnt    <= '0;
          end
        end
        default: begin
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign bus.result_o = r_result;
  assign bus.ready_o  = r_ready;

endmodule
